move_tx_scheduler: RTL
======================

// Module: move_tx_scheduler
// PURPOSE
//  Owns the single UART transmitter on the local side of the link. Wraps local moves in a
//  turn frame '{' <move bytes> '}' so the opponent's receive-side frame decoder can parse it.
//  Also shares the transmitter with an out-of-frame control requester (setup/echo bytes).
//  Sits between the game logic (move producer, turn start/end) and the UART TX core.
// PARAMETERS
//  FIFO_DEPTH  4      move FIFO entries, power of 2, >=2
//  OPEN_BYTE   8'h7B  frame open character '{'
//  CLOSE_BYTE  8'h7D  frame close character '}'
// PORTS
//  clk            in   1  system clock; all logic on rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  my_turn_start  in   1  1-cycle pulse: local turn begins, open a frame
//  turn_end       in   1  1-cycle pulse: local turn over, close frame after queued moves
//  move_valid     in   1  move byte offered
//  move_data      in   8  move byte (direction code)
//  move_ready     out  1  FIFO not full; byte accepted when valid&&ready
//  ctrl_req       in   1  level: control byte pending; hold until ctrl_ack
//  ctrl_data      in   8  control byte, must be stable while ctrl_req is high
//  ctrl_ack       out  1  1-cycle pulse on the cycle the control byte's TxD_start is issued
//  TxD_busy       in   1  UART TX busy
//  TxD_start      out  1  1-cycle start strobe to UART TX
//  TxD_data       out  8  byte to send; valid with TxD_start
//  frame_open     out  1  high from '{' issue until '}' has finished sending
//  frame_done     out  1  1-cycle pulse when '}' has finished sending
//  protocol_err   out  1  sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset values: TxD_start=0, TxD_data=0, ctrl_ack=0, frame_open=0, frame_done=0,
//   protocol_err=0, move_ready=1, FIFO empty, turn_pending=0, end_pending=0, state=IDLE.
//  Reset mid-byte: all state cleared. An in-flight UART byte is not tracked.
//  Latches: my_turn_start sets turn_pending; turn_end sets end_pending.
//   Both are cleared when the FSM consumes them.
//  FIFO:
//   - push on move_valid&&move_ready, accepted in any state, including before the frame opens.
//   - push and pop in the same cycle leaves the count unchanged.
//   - move_ready=0 when full.
//   - move_data equal to OPEN_BYTE or CLOSE_BYTE: not pushed, protocol_err set.
//     The handshake still completes (move_ready is not affected).
//  FSM states and transitions:
//   IDLE:
//    - ctrl_req -> CTRL (control has priority in IDLE only).
//    - else if turn_pending -> OPEN.
//   OPEN, MOVE, CLOSE, CTRL are issue states:
//    - When TxD_busy=0: registered TxD_start=1 with TxD_data = '{' / FIFO head (pop) / '}' /
//      ctrl_data respectively, then go to GUARD.
//    - CTRL also pulses ctrl_ack in that same cycle.
//   GUARD: one cycle with TxD_busy ignored, then -> WAIT.
//   WAIT: stay while TxD_busy=1, then go to the return state:
//    - after '{': frame_open=1, -> INFRAME
//    - after move: -> INFRAME
//    - after '}': frame_open=0, frame_done pulse, -> IDLE
//    - after ctrl: -> IDLE
//   INFRAME:
//    - FIFO non-empty -> MOVE.
//    - else if end_pending -> CLOSE.
//    - ctrl_req is held off until IDLE.
//  Latency: with TxD_busy=0, TxD_start is high on the 2nd cycle after the my_turn_start pulse.
//  Ordering: all moves queued before '}' is issued are sent inside the frame.
//   A move pushed in the same cycle '}' is issued waits for the next frame.
//  Simultaneous my_turn_start and turn_end (in IDLE): both latched.
//   The frame opens, drains the FIFO, then closes.
//  Errors (each sets protocol_err; the event is otherwise ignored):
//   - my_turn_start while frame_open or turn_pending.
//   - turn_end while neither frame_open nor turn_pending.
// STRUCTURE
//  Shared package (paper_soccer_pkg): protocol characters w,l,c,r,b,'{','}',LF and the
//   scheduler state enum, shared with the receive-side frame decoder.
//  One sub-module: move_fifo (synchronous FIFO with FIFO_DEPTH entries, full/empty flags,
//   push/pop same cycle).
//  Top: FSM, pending latches, TX output registers.
// TESTING
//  1 Basic frame: UART model busy for 10 cycles after each start; turn_start, push 8'h31,8'h35,
//    turn_end -> TxD bytes 7B,31,35,7D in order; frame_done one pulse; frame_open low after.
//  2 Back-pressure: push 6 bytes with FIFO_DEPTH=4 and no frame open -> move_ready drops
//    after 4; after turn_start all 6 are sent before '}'.
//  3 Arbitration: ctrl_req(8'h77) and my_turn_start in the same cycle in IDLE -> 77 sent first
//    with ctrl_ack, then 7B; ctrl_req raised inside a frame -> sent only after 7D.
//  4 Errors: turn_end in IDLE -> protocol_err=1, no TxD_start; push 8'h7D -> protocol_err=1,
//    byte not sent.
//  5 Reset mid-frame: rst_n low during WAIT after 2nd move -> all outputs at reset values;
//    a new turn_start afterwards starts a fresh frame with 7B.
//  6 Timing: TxD_busy held high 50 cycles -> no second TxD_start until busy falls;
//    TxD_start is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/paper_soccer_pkg.sv
// Protocol characters and transmit-scheduler state encoding shared by the
// local transmit scheduler and the receive-side frame decoder.
package paper_soccer_pkg;

  localparam logic [7:0] CHAR_W     = 8'h77;
  localparam logic [7:0] CHAR_L     = 8'h6C;
  localparam logic [7:0] CHAR_C     = 8'h63;
  localparam logic [7:0] CHAR_R     = 8'h72;
  localparam logic [7:0] CHAR_B     = 8'h62;
  localparam logic [7:0] CHAR_OPEN  = 8'h7B;
  localparam logic [7:0] CHAR_CLOSE = 8'h7D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN,
    ST_MOVE,
    ST_CLOSE,
    ST_CTRL,
    ST_GUARD,
    ST_WAIT,
    ST_INFRAME
  } sched_state_t;

  // Remembers which kind of byte is in flight so WAIT knows where to return.
  typedef enum logic [1:0] {
    K_OPEN,
    K_MOVE,
    K_CLOSE,
    K_CTRL
  } tx_kind_t;

endpackage

// File: rtl/move_fifo.sv
// Small synchronous FIFO holding queued move bytes; push and pop may
// happen in the same cycle.
module move_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/move_tx_scheduler.sv
// Shares the single UART transmitter between framed local moves ('{' moves '}')
// and out-of-frame control bytes.
module move_tx_scheduler
  import paper_soccer_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] OPEN_BYTE  = CHAR_OPEN,
  parameter logic [7:0] CLOSE_BYTE = CHAR_CLOSE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       my_turn_start,
  input  logic       turn_end,
  input  logic       move_valid,
  input  logic [7:0] move_data,
  output logic       move_ready,
  input  logic       ctrl_req,
  input  logic [7:0] ctrl_data,
  output logic       ctrl_ack,
  input  logic       TxD_busy,
  output logic       TxD_start,
  output logic [7:0] TxD_data,
  output logic       frame_open,
  output logic       frame_done,
  output logic       protocol_err
);

  sched_state_t state;
  tx_kind_t     last_kind;
  logic         turn_pending;
  logic         end_pending;

  logic         fifo_full;
  logic         fifo_empty;
  logic [7:0]   fifo_head;
  logic         bad_move;
  logic         push_ok;
  logic         pop;
  logic         start_err;
  logic         start_ok;
  logic         end_err;
  logic         end_ok;
  logic         open_issue;
  logic         close_issue;

  assign move_ready = !fifo_full;
  assign bad_move   = (move_data == OPEN_BYTE) || (move_data == CLOSE_BYTE);
  assign push_ok    = move_valid && move_ready && !bad_move;
  assign pop        = (state == ST_MOVE) && !TxD_busy;

  // A turn_end in the same cycle as an accepted my_turn_start is legal.
  assign start_err   = my_turn_start && (frame_open || turn_pending);
  assign start_ok    = my_turn_start && !start_err;
  assign end_err     = turn_end && !(frame_open || turn_pending || start_ok);
  assign end_ok      = turn_end && !end_err;
  assign open_issue  = (state == ST_OPEN) && !TxD_busy;
  assign close_issue = (state == ST_CLOSE) && !TxD_busy && fifo_empty;

  move_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data (move_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      last_kind    <= K_OPEN;
      turn_pending <= 1'b0;
      end_pending  <= 1'b0;
      TxD_start    <= 1'b0;
      TxD_data     <= 8'h00;
      ctrl_ack     <= 1'b0;
      frame_open   <= 1'b0;
      frame_done   <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      TxD_start  <= 1'b0;
      ctrl_ack   <= 1'b0;
      frame_done <= 1'b0;

      if (start_err || end_err || (move_valid && move_ready && bad_move))
        protocol_err <= 1'b1;

      // Pending flags stay up until their byte is actually issued.
      if (open_issue)    turn_pending <= 1'b0;
      else if (start_ok) turn_pending <= 1'b1;
      if (close_issue)   end_pending  <= 1'b0;
      else if (end_ok)   end_pending  <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (ctrl_req)                      state <= ST_CTRL;
          else if (turn_pending || start_ok) state <= ST_OPEN;
        end
        ST_OPEN: begin
          if (!TxD_busy) begin
            TxD_start  <= 1'b1;
            TxD_data   <= OPEN_BYTE;
            frame_open <= 1'b1;
            last_kind  <= K_OPEN;
            state      <= ST_GUARD;
          end
        end
        ST_MOVE: begin
          if (!TxD_busy) begin
            TxD_start <= 1'b1;
            TxD_data  <= fifo_head;
            last_kind <= K_MOVE;
            state     <= ST_GUARD;
          end
        end
        // A move that slipped in while waiting to close still belongs to this frame.
        ST_CLOSE: begin
          if (!fifo_empty) begin
            state <= ST_MOVE;
          end else if (!TxD_busy) begin
            TxD_start <= 1'b1;
            TxD_data  <= CLOSE_BYTE;
            last_kind <= K_CLOSE;
            state     <= ST_GUARD;
          end
        end
        ST_CTRL: begin
          if (!TxD_busy) begin
            TxD_start <= 1'b1;
            TxD_data  <= ctrl_data;
            ctrl_ack  <= 1'b1;
            last_kind <= K_CTRL;
            state     <= ST_GUARD;
          end
        end
        ST_GUARD: state <= ST_WAIT;
        ST_WAIT: begin
          if (!TxD_busy) begin
            case (last_kind)
              K_OPEN, K_MOVE: state <= ST_INFRAME;
              K_CLOSE: begin
                frame_open <= 1'b0;
                frame_done <= 1'b1;
                state      <= ST_IDLE;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_INFRAME: begin
          if (!fifo_empty)      state <= ST_MOVE;
          else if (end_pending) state <= ST_CLOSE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
